// File: rtl/keypad_scan.sv
// rtl/keypad_scan.sv - 4x4 hex keypad row scanner with per-scan debounce and hex key decode
// Rows are driven active-low one at a time; a press or release is accepted after DEBOUNCE_SCANS identical full scans.
module keypad_scan #(
  parameter int ROW_CYCLES     = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DW = $clog2(ROW_CYCLES);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(ROW_CYCLES - 1);
  localparam logic [CW-1:0] DB_DONE    = CW'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    RELEASED = 2'd0,
    PRESS_DB = 2'd1,
    PRESSED  = 2'd2,
    REL_DB   = 2'd3
  } state_e;

  // Reset asserts asynchronously, releases on a CLK edge so no flop sees a runt deassertion.
  logic rst_meta_q;
  logic rst_sync_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end

  logic [3:0]    col_meta_q;
  logic [3:0]    col_sync_q;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [1:0]    row_q, row_d;
  logic [11:0]   acc_q, acc_d;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    cand_q, cand_d;
  logic [3:0]    code_q, code_d;
  logic          valid_q, valid_d;

  logic          row_last;
  logic          scan_eval;
  logic [3:0]    row_hits;
  logic [15:0]   scan_keys;
  logic [4:0]    hit_count;
  logic [3:0]    hit_idx;
  logic          scan_none;
  logic          scan_one;
  logic [CW-1:0] cnt_inc;

  function automatic logic [3:0] key_map(input logic [3:0] idx);
    case (idx)
      4'd0:    key_map = 4'h1;
      4'd1:    key_map = 4'h2;
      4'd2:    key_map = 4'h3;
      4'd3:    key_map = 4'hA;
      4'd4:    key_map = 4'h4;
      4'd5:    key_map = 4'h5;
      4'd6:    key_map = 4'h6;
      4'd7:    key_map = 4'hB;
      4'd8:    key_map = 4'h7;
      4'd9:    key_map = 4'h8;
      4'd10:   key_map = 4'h9;
      4'd11:   key_map = 4'hC;
      4'd12:   key_map = 4'h0;
      4'd13:   key_map = 4'hF;
      4'd14:   key_map = 4'hE;
      default: key_map = 4'hD;
    endcase
  endfunction

  assign row_last  = (dwell_q == DWELL_LAST);
  assign scan_eval = row_last && (row_q == 2'd3);
  assign row_hits  = ~col_sync_q;
  // Rows 0..2 come from earlier samples; row 3 is taken live on the evaluation cycle.
  assign scan_keys = {row_hits, acc_q};
  assign row_out   = ~(4'b0001 << row_q);
  assign cnt_inc   = cnt_q + CW'(1);

  always_ff @(posedge CLK or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      col_meta_q <= 4'hF;
      col_sync_q <= 4'hF;
      dwell_q    <= '0;
      row_q      <= 2'd0;
      acc_q      <= '0;
      state_q    <= RELEASED;
      cnt_q      <= '0;
      cand_q     <= 4'h0;
      code_q     <= 4'h0;
      valid_q    <= 1'b0;
    end else begin
      col_meta_q <= col_in;
      col_sync_q <= col_meta_q;
      dwell_q    <= dwell_d;
      row_q      <= row_d;
      acc_q      <= acc_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cand_q     <= cand_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
    end
  end

  always_comb begin
    dwell_d = row_last ? '0 : dwell_q + DW'(1);
    row_d   = row_last ? row_q + 2'd1 : row_q;
    acc_d   = acc_q;
    if (row_last) begin
      case (row_q)
        2'd0:    acc_d[3:0]  = row_hits;
        2'd1:    acc_d[7:4]  = row_hits;
        2'd2:    acc_d[11:8] = row_hits;
        default: acc_d       = acc_q;
      endcase
    end
  end

  always_comb begin
    hit_count = '0;
    hit_idx   = '0;
    for (int i = 0; i < 16; i++) begin
      if (scan_keys[i]) begin
        hit_count = hit_count + 5'd1;
        hit_idx   = 4'(i);
      end
    end
  end

  assign scan_none = (hit_count == 5'd0);
  assign scan_one  = (hit_count == 5'd1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    code_d  = code_q;
    valid_d = 1'b0;
    if (scan_eval) begin
      case (state_q)
        RELEASED: begin
          if (scan_one) begin
            state_d = PRESS_DB;
            cand_d  = hit_idx;
            cnt_d   = CW'(1);
          end
        end
        PRESS_DB: begin
          if (scan_one && (hit_idx == cand_q)) begin
            if (cnt_inc == DB_DONE) begin
              state_d = PRESSED;
              cnt_d   = '0;
              code_d  = key_map(cand_q);
              valid_d = 1'b1;
            end else begin
              cnt_d = cnt_inc;
            end
          end else if (scan_one) begin
            cand_d = hit_idx;
            cnt_d  = CW'(1);
          end else begin
            state_d = RELEASED;
            cnt_d   = '0;
          end
        end
        PRESSED: begin
          // No rollover: any key activity keeps the current press alive.
          if (scan_none) begin
            state_d = REL_DB;
            cnt_d   = CW'(1);
          end
        end
        REL_DB: begin
          if (scan_none) begin
            if (cnt_inc == DB_DONE) begin
              state_d = RELEASED;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = PRESSED;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = RELEASED;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    key_held  = (state_q == PRESSED) || (state_q == REL_DB);
    key_valid = valid_q;
    key_code  = code_q;
  end

endmodule

// File: tb/tb_keypad_scan.sv
// tb/tb_keypad_scan.sv - directed and random keypad scenarios against a per-scan debounce reference model
module tb_keypad_scan;

  localparam int ROWC = 8;
  localparam int DB   = 3;
  localparam int SCAN = 4 * ROWC;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b1;
  logic [3:0]  col_in;
  logic [3:0]  row_out;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;

  logic [15:0] keys_down = '0;
  logic [3:0]  keymap [16];

  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_pulses = 0;

  bit          m_held;
  int          m_cnt;
  int          m_cand;
  logic [3:0]  m_code;

  keypad_scan #(.ROW_CYCLES(ROWC), .DEBOUNCE_SCANS(DB)) dut (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .col_in   (col_in),
    .row_out  (row_out),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  always #5 CLK = ~CLK;

  // Keypad matrix: a pressed key shorts its column to its row while that row is driven low.
  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_out[r] && keys_down[r*4+c]) col_in[c] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_held = 0;
    m_cnt  = 0;
    m_cand = 0;
    m_code = 4'h0;
  endtask

  // One full-scan verdict: held plus a nonzero count means a debounce is in progress.
  task automatic model_eval(input logic [15:0] keys, output bit pulse);
    int n;
    int k;
    n = $countones(keys);
    k = 0;
    for (int i = 0; i < 16; i++) if (keys[i]) k = i;
    pulse = 0;
    if (!m_held) begin
      if (n == 1) begin
        if (m_cnt > 0 && k == m_cand) m_cnt++;
        else begin
          m_cand = k;
          m_cnt  = 1;
        end
        if (m_cnt == DB) begin
          m_held = 1;
          m_cnt  = 0;
          m_code = keymap[k];
          pulse  = 1;
        end
      end else begin
        m_cnt = 0;
      end
    end else begin
      if (n == 0) begin
        m_cnt++;
        if (m_cnt == DB) begin
          m_held = 0;
          m_cnt  = 0;
        end
      end else begin
        m_cnt = 0;
      end
    end
  endtask

  task automatic scan(input logic [15:0] keys);
    bit         pulse;
    logic [3:0] exp_row;
    keys_down = keys;
    for (int i = 0; i < SCAN; i++) begin
      @(posedge CLK);
      #1;
      pulse = 0;
      if (i == SCAN - 1) model_eval(keys, pulse);
      exp_row = 4'b0001 << (((i + 1) % SCAN) / ROWC);
      exp_row = ~exp_row;
      if (key_valid) n_pulses++;
      check("row_out", row_out, exp_row);
      check("key_valid", key_valid, pulse);
      check("key_held", key_held, m_held);
      check("key_code", key_code, m_code);
    end
  endtask

  task automatic scans(input logic [15:0] keys, input int n);
    for (int i = 0; i < n; i++) scan(keys);
  endtask

  task automatic apply_reset(input int mid_cycles);
    repeat (mid_cycles) @(posedge CLK);
    #2;
    RESET_N = 1'b0;
    #1;
    model_reset();
    check("rst_row_out", row_out, 4'b1110);
    check("rst_key_code", key_code, 4'h0);
    check("rst_key_valid", key_valid, 1'b0);
    check("rst_key_held", key_held, 1'b0);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RESET_N = 1'b1;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    check("rst_release_row", row_out, 4'b1110);
  endtask

  initial begin
    int          p0;
    int          r;
    logic [15:0] cur;

    keymap = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
               4'h7, 4'h8, 4'h9, 4'hC, 4'h0, 4'hF, 4'hE, 4'hD};
    model_reset();

    apply_reset(0);
    scans(16'h0000, 2);
    apply_reset(13);
    scans(16'h0000, 1);

    // '6' at r1c2
    p0 = n_pulses;
    scans(16'h0040, DB);
    check("t2_pulses", n_pulses - p0, 1);
    check("t2_code", key_code, 4'h6);
    scans(16'h0000, DB);
    check("t2_held_off", key_held, 1'b0);
    check("t2_code_kept", key_code, 4'h6);

    // '9' at r2c2 with a one-scan bounce
    p0 = n_pulses;
    scans(16'h0400, 2);
    scans(16'h0000, 1);
    scans(16'h0400, 2);
    check("t3_no_early", n_pulses - p0, 0);
    scans(16'h0400, 1);
    check("t3_pulses", n_pulses - p0, 1);
    check("t3_code", key_code, 4'h9);
    scans(16'h0000, DB);

    // '1' and '5' together, then '5' released
    p0 = n_pulses;
    scans(16'h0021, 10);
    check("t4_multi_pulses", n_pulses - p0, 0);
    check("t4_multi_held", key_held, 1'b0);
    scans(16'h0001, DB);
    check("t4_pulses", n_pulses - p0, 1);
    check("t4_code", key_code, 4'h1);
    scans(16'h0000, DB);

    p0 = n_pulses;
    for (int k = 0; k < 16; k++) begin
      cur = 16'h0001 << k;
      scans(cur, DB);
      check("t5_code", key_code, keymap[k]);
      scans(16'h0000, DB);
    end
    check("t5_pulses", n_pulses - p0, 16);

    // 'A' held, 'B' added, reset while 'A' still down
    p0 = n_pulses;
    scans(16'h0008, DB);
    scans(16'h0088, DB);
    check("t6_pulses", n_pulses - p0, 1);
    check("t6_held", key_held, 1'b1);
    keys_down = 16'h0008;
    apply_reset(10);
    scans(16'h0008, DB);
    check("t6_reaccept", n_pulses - p0, 2);
    check("t6_code", key_code, 4'hA);
    scans(16'h0000, DB);

    cur = '0;
    for (int s = 0; s < 60; s++) begin
      r = $urandom_range(0, 9);
      if (r >= 4 && r <= 6) cur = '0;
      else if (r >= 7 && r <= 8) cur = 16'h0001 << $urandom_range(0, 15);
      else if (r == 9) cur = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
      scan(cur);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
